// File: rtl/vga_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan_controller
// Purpose  : VGA 640x480@60 scan sequencer for the debug display path.
//            Divides the system clock down to the pixel rate and drives the
//            scan coordinates used by the combinational renderer. It registers
//            the renderer colour together with hsync/vsync so that all of
//            them leave aligned. Once per frame, during vertical blanking,
//            it also captures a snapshot of the CPU debug state.
// Revision : 1.0 - initial release
// ============================================================================
module vga_scan_controller #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         freeze,
  input  logic [175:0] registers_in,
  input  logic [15:0]  if_pc_in,
  input  logic [15:0]  if_ir_in,
  input  logic [2:0]   r_in,
  input  logic [2:0]   g_in,
  input  logic [2:0]   b_in,
  output logic [10:0]  x,
  output logic [10:0]  y,
  output logic [175:0] registers_snap,
  output logic [15:0]  if_pc_snap,
  output logic [15:0]  if_ir_snap,
  output logic [2:0]   vga_r,
  output logic [2:0]   vga_g,
  output logic [2:0]   vga_b,
  output logic         hsync,
  output logic         vsync,
  output logic         frame_start,
  output logic [15:0]  frame_count
);

  localparam int c_h_total = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int c_v_total = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int c_div_w   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [10:0] c_h_last    = 11'(c_h_total - 1);
  localparam logic [10:0] c_v_last    = 11'(c_v_total - 1);
  localparam logic [10:0] c_h_vis     = 11'(H_VISIBLE);
  localparam logic [10:0] c_v_vis     = 11'(V_VISIBLE);
  localparam logic [10:0] c_v_vis_end = 11'(V_VISIBLE - 1);
  localparam logic [10:0] c_hs_first  = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] c_hs_last   = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] c_vs_first  = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] c_vs_last   = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic         w_pe;
  logic         w_visible;
  logic         w_hs_active;
  logic         w_vs_active;
  logic         w_snap_evt;

  logic [10:0]  r_hc;
  logic [10:0]  r_vc;
  logic [2:0]   r_vga_r;
  logic [2:0]   r_vga_g;
  logic [2:0]   r_vga_b;
  logic         r_hsync;
  logic         r_vsync;
  logic [15:0]  r_frame_count;
  logic [175:0] r_regs_snap;
  logic [15:0]  r_pc_snap;
  logic [15:0]  r_ir_snap;

  // Pixel-enable generation: one pulse every CLK_DIV system clocks.
  generate
    if (CLK_DIV > 1) begin : g_div
      localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
      logic [c_div_w-1:0] r_div;

      // Divider counter, restarting from zero after its terminal count.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_div <= '0;
        end else if (r_div == c_div_last) begin
          r_div <= '0;
        end else begin
          r_div <= r_div + c_div_w'(1);
        end
      end

      assign w_pe = (r_div == c_div_last);
    end else begin : g_nodiv
      assign w_pe = 1'b1;
    end
  endgenerate

  // Decode of the current counter position.
  assign w_visible   = (r_hc < c_h_vis) && (r_vc < c_v_vis);
  assign w_hs_active = (r_hc >= c_hs_first) && (r_hc <= c_hs_last);
  assign w_vs_active = (r_vc >= c_vs_first) && (r_vc <= c_vs_last);

  // Capture point: the last pixel of the last visible line, just before the
  // scan enters vertical blanking. Reset suppresses it.
  assign w_snap_evt  = w_pe && !rst && (r_hc == c_h_last) && (r_vc == c_v_vis_end);

  // Horizontal and vertical scan counters, advanced once per pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (w_pe) begin
      if (r_hc == c_h_last) begin
        r_hc <= '0;
        r_vc <= (r_vc == c_v_last) ? 11'd0 : r_vc + 11'd1;
      end else begin
        r_hc <= r_hc + 11'd1;
      end
    end
  end

  // Colour and sync registered together so they stay aligned one pixel behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vga_r <= '0;
      r_vga_g <= '0;
      r_vga_b <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else if (w_pe) begin
      r_vga_r <= w_visible ? r_in : 3'd0;
      r_vga_g <= w_visible ? g_in : 3'd0;
      r_vga_b <= w_visible ? b_in : 3'd0;
      r_hsync <= !w_hs_active;
      r_vsync <= !w_vs_active;
    end
  end

  // Frame counter, stepped once per capture point.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_count <= '0;
    end else if (w_snap_evt) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  // Debug-state snapshot, loaded only at the capture point and only when not frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_regs_snap <= '0;
      r_pc_snap   <= '0;
      r_ir_snap   <= '0;
    end else if (w_snap_evt && !freeze) begin
      r_regs_snap <= registers_in;
      r_pc_snap   <= if_pc_in;
      r_ir_snap   <= if_ir_in;
    end
  end

  assign x              = r_hc;
  assign y              = r_vc;
  assign vga_r          = r_vga_r;
  assign vga_g          = r_vga_g;
  assign vga_b          = r_vga_b;
  assign hsync          = r_hsync;
  assign vsync          = r_vsync;
  assign frame_start    = w_snap_evt;
  assign frame_count    = r_frame_count;
  assign registers_snap = r_regs_snap;
  assign if_pc_snap     = r_pc_snap;
  assign if_ir_snap     = r_ir_snap;

endmodule
`default_nettype wire

// File: doc/vga_scan_controller.md
# vga_scan_controller

Scan sequencer for the debug display path. Generates 640x480@60 VGA timing from the system clock, drives the pixel coordinates consumed by the combinational screen renderer, registers the renderer's colour output together with sync so they leave aligned, and captures a per-frame snapshot of CPU debug state (register heap, IF-stage PC/IR) during vertical blanking. The renderer therefore sees stable values for the whole visible frame.

## Interface
Parameters:
- CLK_DIV, 2, system clocks per pixel (50 MHz -> 25 MHz pixel rate); must be >= 1
- H_VISIBLE, 640; H_FRONT, 16; H_SYNC, 96; H_BACK, 48 (pixels)
- V_VISIBLE, 480; V_FRONT, 10; V_SYNC, 2; V_BACK, 33 (lines)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous and active-high
- freeze  in  1  when high, the snapshot is not updated
- registers_in  in  176  live register heap
- if_pc_in, if_ir_in  in  16 each  live IF-stage PC/IR
- r_in, g_in, b_in  in  3 each  renderer colour for current x/y
- x, y  out  11 each  current scan coordinates to renderer
- registers_snap  out  176  frame snapshot of registers_in
- if_pc_snap, if_ir_snap  out  16 each  frame snapshot
- vga_r, vga_g, vga_b  out  3 each  registered colour to DAC
- hsync, vsync  out  1 each  active-low sync
- frame_start  out  1  one-clock pulse at snapshot capture
- frame_count  out  16  frames completed, wraps

## Operation
- Divider: counter div 0..CLK_DIV-1; pixel enable pe is high in the clock where div = CLK_DIV-1 (every clock if CLK_DIV=1).
- H_TOTAL = sum of H parameters (800); V_TOTAL = sum of V parameters (525).
- On pe: hc increments; at H_TOTAL-1 it wraps to 0 and vc increments; vc wraps from V_TOTAL-1 to 0. x = hc and y = vc, driven directly from the counters.
- visible = (hc < H_VISIBLE) && (vc < V_VISIBLE).
- On pe: vga_r/g/b <= visible ? r_in/g_in/b_in : 0.
- On pe: hsync <= !(hc in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]); vsync is computed the same way from vc with the V parameters.
- Snapshot event: on pe, when the counters are about to move to hc=0, vc=V_VISIBLE (i.e. hc=H_TOTAL-1, vc=V_VISIBLE-1). On that clock:
  - frame_start = 1 for exactly one clk.
  - frame_count increments modulo 2^16.
  - If freeze=0, the snapshot registers load the live inputs; if freeze=1 they hold.
- The snapshot is only written at that event. Inputs changing at any other time have no effect on the snapshot outputs.

## Timing
- Reset (rst high at clk edge): div=0, hc=0, vc=0, so x=0 and y=0. vga_r/g/b=0, hsync=1, vsync=1, frame_start=0, frame_count=0, all snapshots 0. rst takes priority over pe and over the snapshot event. Asserting rst mid-line or mid-frame restarts the scan at (0,0) on the next clock.
- Colour/sync latency: outputs reflect the counter state from the previous pe, i.e. one pixel of delay. Colour and sync stay mutually aligned.
- Outputs change only on pe clocks. frame_start is the exception; it is a single-clk pulse that occurs on a pe clock.
- First pe after reset release is CLK_DIV clocks later.
- Snapshot values are valid from the clock after frame_start and stay valid through the entire next visible frame.
- Frame period: H_TOTAL*V_TOTAL*CLK_DIV clocks = 840000 clocks at the defaults.

## Test plan
- Reset, then run 1600 clks -> x goes 0..799 and wraps to 0; y goes 0 -> 1 at the wrap; each x value is held for 2 clks.
- hsync checked over a full line -> low for exactly 96 pixels (192 clks), starting at the pe after hc=656; vsync low for 2 lines starting the line after vc=490.
- r_in=g_in=b_in=5 held constant -> vga_* = 5 exactly during the pixel after each visible coordinate and 0 in every blank pixel, including hc=640 and vc=480.
- registers_in=176'h1234..., if_pc_in=16'hABCD, freeze=0, change the inputs mid-frame -> snapshots take the values present at the frame_start clock (first frame_start at clk 2*(800*480)-1 after reset release) and hold until the next frame_start.
- freeze=1 across a frame_start -> snapshots unchanged; frame_start still pulses and frame_count increments from 0 to 1.
- rst asserted at x=300, y=200 -> next clock x=0, y=0, vga_*=0, hsync=vsync=1, frame_count=0.
